// File: rtl/audio_pkg.sv
// Shared definitions for the serial audio link (S2P / P2S).
//   SAMPLE_W    : sample width in bits
//   MUTE_SAMPLE : word sent when no sample is available at a frame start
//   p2s_state_e : transmitter sequencing states
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;

  localparam logic [SAMPLE_W-1:0] MUTE_SAMPLE = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } p2s_state_e;

endpackage

// File: rtl/p2s_tx_if.sv
// Upstream sample-pair handshake into the P2S transmitter.
//   P2S_L, P2S_R : left/right two's-complement samples
//   P2S_valid    : pair is valid (driven by the processing core)
//   P2S_ready    : transmitter hold buffer is empty
// A pair transfers on a rising Dclk edge with valid and ready both high.
interface p2s_tx_if;
  import audio_pkg::*;

  logic [SAMPLE_W-1:0] P2S_L;
  logic [SAMPLE_W-1:0] P2S_R;
  logic                P2S_valid;
  logic                P2S_ready;

  modport master (
    output P2S_L,
    output P2S_R,
    output P2S_valid,
    input  P2S_ready
  );

  modport slave (
    input  P2S_L,
    input  P2S_R,
    input  P2S_valid,
    output P2S_ready
  );

endinterface

// File: rtl/p2s_lane.sv
// One serial lane: 16-bit load / shift-left register, serial output from the MSB.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load data_i (frame start)
//   shift_i       : shift left by one, zero fill
//   clear_i       : force the register to zero (lane idles low)
//   data_i        : parallel word to load
//   ser_o         : serial bit (register MSB, so it is a registered output)
// Priority: clear > load > shift.
module p2s_lane
  import audio_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic                clear_i,
  input  logic [SAMPLE_W-1:0] data_i,
  output logic                ser_o
);

  logic [SAMPLE_W-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (clear_i) begin
      shreg_d = '0;
    end else if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[SAMPLE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign ser_o = shreg_q[SAMPLE_W-1];

endmodule

// File: rtl/p2s_tx.sv
// Stereo parallel-to-serial transmitter (send side of the Frame/Dclk link).
//   FRAME_LEN  : Dclk cycles between Frame strobes (16..255; 16 = back-to-back words)
//   Dclk       : bit clock, all logic on the rising edge
//   Reset_n    : asynchronous active-low reset
//   up         : sample-pair handshake (slave side)
//   Frame      : one-cycle strobe coincident with bit 15 of each word
//   OutputL/R  : serial lanes, MSB first, 0 outside words
//   P2S_status : high while bits 15..0 are on the lanes
//   Underrun   : pulses with Frame when the slot started with no sample held
// Once a first pair arrives the frame timing free-runs; missing data is sent as mute.
module p2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic      Dclk,
  input  logic      Reset_n,
  p2s_tx_if.slave   up,
  output logic      Frame,
  output logic      OutputL,
  output logic      OutputR,
  output logic      P2S_status,
  output logic      Underrun
);

  localparam logic [7:0] LastTick = 8'(FRAME_LEN - 1);
  localparam logic [4:0] LastBit  = 5'(SAMPLE_W - 1);
  localparam bit         HasGap   = (FRAME_LEN > SAMPLE_W);

  p2s_state_e          state_q;
  logic [4:0]          bit_cnt_q;
  logic [7:0]          timer_q;
  logic [SAMPLE_W-1:0] hold_l_q, hold_r_q;
  logic                hold_full_q, hold_full_d;
  logic                ready_q;
  logic                frame_q, status_q, underrun_q;

  logic                frame_start, word_end, accept;
  logic                lane_load, lane_shift, lane_clear;
  logic [SAMPLE_W-1:0] load_l, load_r;

  always_comb begin
    frame_start = 1'b0;
    word_end    = 1'b0;
    case (state_q)
      StIdle:  frame_start = hold_full_q;
      StShift: begin
        if (bit_cnt_q == LastBit) begin
          word_end    = 1'b1;
          frame_start = !HasGap;
        end
      end
      StGap:   frame_start = (timer_q == LastTick);
      default: ;
    endcase
  end

  // Accept and drain are mutually exclusive: accept needs ready (hold empty),
  // drain needs hold full.
  assign accept = up.P2S_valid && ready_q;

  always_comb begin
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_full_d = 1'b1;
    end else if (frame_start) begin
      hold_full_d = 1'b0;
    end
  end

  assign lane_load  = frame_start;
  assign lane_shift = (state_q == StShift) && !word_end;
  assign lane_clear = word_end && !frame_start;
  assign load_l     = hold_full_q ? hold_l_q : MUTE_SAMPLE;
  assign load_r     = hold_full_q ? hold_r_q : MUTE_SAMPLE;

  always_ff @(posedge Dclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      frame_q     <= 1'b0;
      status_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      frame_q     <= frame_start;
      underrun_q  <= frame_start && !hold_full_q;
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      if (accept) begin
        hold_l_q <= up.P2S_L;
        hold_r_q <= up.P2S_R;
      end
      if (frame_start) begin
        state_q   <= StShift;
        bit_cnt_q <= '0;
        timer_q   <= '0;
        status_q  <= 1'b1;
      end else begin
        case (state_q)
          StShift: begin
            timer_q <= timer_q + 8'd1;
            if (word_end) begin
              state_q  <= StGap;
              status_q <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
          StGap:   timer_q <= timer_q + 8'd1;
          default: ;
        endcase
      end
    end
  end

  p2s_lane u_lane_l (
    .clk_i   (Dclk),
    .rst_ni  (Reset_n),
    .load_i  (lane_load),
    .shift_i (lane_shift),
    .clear_i (lane_clear),
    .data_i  (load_l),
    .ser_o   (OutputL)
  );

  p2s_lane u_lane_r (
    .clk_i   (Dclk),
    .rst_ni  (Reset_n),
    .load_i  (lane_load),
    .shift_i (lane_shift),
    .clear_i (lane_clear),
    .data_i  (load_r),
    .ser_o   (OutputR)
  );

  assign up.P2S_ready = ready_q;
  assign Frame        = frame_q;
  assign P2S_status   = status_q;
  assign Underrun     = underrun_q;

endmodule

// File: tb/tb_p2s_tx.sv
// Bench for p2s_tx: one instance with FRAME_LEN=16 and one with FRAME_LEN=20,
// each followed by a falling-edge loopback receiver that collects words.
module tb_p2s_tx;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  p2s_tx_if if16 ();
  p2s_tx_if if20 ();

  logic fr16, ol16, or16, st16, un16;
  logic fr20, ol20, or20, st20, un20;

  p2s_tx #(.FRAME_LEN(16)) dut16 (
    .Dclk       (clk),
    .Reset_n    (rst_n),
    .up         (if16),
    .Frame      (fr16),
    .OutputL    (ol16),
    .OutputR    (or16),
    .P2S_status (st16),
    .Underrun   (un16)
  );

  p2s_tx #(.FRAME_LEN(20)) dut20 (
    .Dclk       (clk),
    .Reset_n    (rst_n),
    .up         (if20),
    .Frame      (fr20),
    .OutputL    (ol20),
    .OutputR    (or20),
    .P2S_status (st20),
    .Underrun   (un20)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        und;
    int          t;
  } rx_t;

  typedef struct {
    int          cnt;
    logic [15:0] sl;
    logic [15:0] sr;
    logic        und;
    int          t;
    int          nfr;
    int          errs;
    logic        prev_f;
  } rxs_t;

  rx_t  rx16[$];
  rx_t  rx20[$];
  rxs_t rs16 = '{cnt: 0, sl: 0, sr: 0, und: 0, t: 0, nfr: 0, errs: 0, prev_f: 0};
  rxs_t rs20 = '{cnt: 0, sl: 0, sr: 0, und: 0, t: 0, nfr: 0, errs: 0, prev_f: 0};

  int n_pass = 0;
  int n_total = 0;

  // Receiver step: protocol violations (long Frame, stray Underrun, status or
  // lane activity outside a word) accumulate in errs.
  task automatic rx_step(input logic fi, input logic li, input logic ri, input logic sti,
                         input logic ui, inout rxs_t rs, output bit push, output rx_t w);
    push = 1'b0;
    w    = '{l: 0, r: 0, und: 0, t: 0};
    if (fi) begin
      if (rs.prev_f) rs.errs++;
      rs.nfr++;
      rs.cnt = 0;
      rs.t   = cyc;
      rs.und = ui;
    end else if (ui) begin
      rs.errs++;
    end
    rs.prev_f = fi;
    if (fi || rs.cnt != 0) begin
      if (!sti) rs.errs++;
      rs.sl = {rs.sl[14:0], li};
      rs.sr = {rs.sr[14:0], ri};
      rs.cnt++;
      if (rs.cnt == 16) begin
        push  = 1'b1;
        w.l   = rs.sl;
        w.r   = rs.sr;
        w.und = rs.und;
        w.t   = rs.t;
        rs.cnt = 0;
      end
    end else if (sti || li || ri) begin
      rs.errs++;
    end
  endtask

  bit  p16, p20;
  rx_t w16, w20;

  always @(negedge clk) begin
    if (!rst_n) begin
      rs16.cnt    = 0;
      rs16.prev_f = 1'b0;
    end else begin
      rx_step(fr16, ol16, or16, st16, un16, rs16, p16, w16);
      if (p16) rx16.push_back(w16);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rs20.cnt    = 0;
      rs20.prev_f = 1'b0;
    end else begin
      rx_step(fr20, ol20, or20, st20, un20, rs20, p20, w20);
      if (p20) rx20.push_back(w20);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int probe(input bit sel, input int kind);
    if (kind == 0) return sel ? rs20.nfr : rs16.nfr;
    if (kind == 1) return sel ? rx20.size() : rx16.size();
    return sel ? int'(if20.P2S_ready) : int'(if16.P2S_ready);
  endfunction

  // kind 0: frames started, 1: words received, 2: ready level
  task automatic wait_until(input bit sel, input int kind, input int target, input string name);
    int n = 0;
    while (probe(sel, kind) < target && n < 400) begin
      tick();
      n++;
    end
    if (probe(sel, kind) < target) begin
      n_total++;
      $display("FAIL %s: timed out, got %0d, expected %0d", name, probe(sel, kind), target);
    end
  endtask

  function automatic rx_t rxget(input bit sel, input int i);
    rx_t d = '{l: 16'hxxxx, r: 16'hxxxx, und: 1'bx, t: -1};
    if (sel && i < rx20.size()) d = rx20[i];
    if (!sel && i < rx16.size()) d = rx16[i];
    return d;
  endfunction

  task automatic send(input bit sel, input logic [15:0] l, input logic [15:0] r,
                      output int acc_t);
    wait_until(sel, 2, 1, "send_ready");
    if (sel) begin
      if20.P2S_L = l; if20.P2S_R = r; if20.P2S_valid = 1'b1;
    end else begin
      if16.P2S_L = l; if16.P2S_R = r; if16.P2S_valid = 1'b1;
    end
    acc_t = cyc + 1;
    tick();
    if (sel) if20.P2S_valid = 1'b0;
    else     if16.P2S_valid = 1'b0;
  endtask

  typedef struct {
    bit          valid;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        exp_und;
  } vec_t;

  vec_t tbl[6];
  vec_t stbl[8];
  int   acc20[8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, acc0, base, sz;
    rx_t  w;

    tbl[0] = '{1, 16'hA5C3, 16'h0F0F, 16'b1010010111000011, 16'b0000111100001111, 1'b0};
    tbl[1] = '{0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b1};
    tbl[2] = '{1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 1'b0};
    tbl[3] = '{1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1'b0};
    tbl[4] = '{0, 16'h3333, 16'h4444, 16'h0000, 16'h0000, 1'b1};
    tbl[5] = '{1, 16'h1234, 16'hCDEF, 16'h1234, 16'hCDEF, 1'b0};
    for (int i = 0; i < 8; i++) begin
      stbl[i] = '{1, 16'(i + 1), 16'h8000 | 16'(i + 1), 16'(i + 1), 16'h8000 | 16'(i + 1), 1'b0};
    end

    if16.P2S_valid = 1'b0; if16.P2S_L = '0; if16.P2S_R = '0;
    if20.P2S_valid = 1'b0; if20.P2S_L = '0; if20.P2S_R = '0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_frame", fr16, 1'b0);
    check("rst_outl", ol16, 1'b0);
    check("rst_outr", or16, 1'b0);
    check("rst_status", st16, 1'b0);
    check("rst_underrun", un16, 1'b0);
    check("rst_ready16", if16.P2S_ready, 1'b1);
    check("rst_ready20", if20.P2S_ready, 1'b1);
    rst_n = 1'b1;

    // Idle with no valid: no frames, lanes low, ready high
    repeat (50) tick();
    check("idle_frames16", rs16.nfr, 0);
    check("idle_frames20", rs20.nfr, 0);
    check("idle_ready16", if16.P2S_ready, 1'b1);
    check("idle_ready20", if20.P2S_ready, 1'b1);
    check("idle_outl", ol16, 1'b0);
    check("idle_outr", or16, 1'b0);

    // FRAME_LEN=16: data words and underrun slots, back-to-back
    acc0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].valid) begin
        send(1'b0, tbl[i].l, tbl[i].r, acc);
        if (i == 0) acc0 = acc;
      end
      wait_until(1'b0, 0, i + 1, "tbl_frame");
    end
    wait_until(1'b0, 1, 6, "tbl_words");
    for (int i = 0; i < 6; i++) begin
      w = rxget(1'b0, i);
      check($sformatf("tbl%0d_l", i), w.l, tbl[i].exp_l);
      check($sformatf("tbl%0d_r", i), w.r, tbl[i].exp_r);
      check($sformatf("tbl%0d_und", i), w.und, tbl[i].exp_und);
      if (i > 0) check($sformatf("tbl%0d_spacing", i), w.t - rxget(1'b0, i - 1).t, 16);
    end
    check("first_latency", rxget(1'b0, 0).t, acc0 + 1);

    // FRAME_LEN=20: valid held continuously, pairs 1..8
    if20.P2S_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if20.P2S_L = stbl[i].l;
      if20.P2S_R = stbl[i].r;
      wait_until(1'b1, 2, 1, "stream_ready");
      acc20[i] = cyc + 1;
      tick();
    end
    if20.P2S_valid = 1'b0;
    wait_until(1'b1, 1, 8, "stream_words");
    for (int i = 0; i < 8; i++) begin
      w = rxget(1'b1, i);
      check($sformatf("stream%0d_l", i), w.l, stbl[i].exp_l);
      check($sformatf("stream%0d_r", i), w.r, stbl[i].exp_r);
      check($sformatf("stream%0d_und", i), w.und, stbl[i].exp_und);
      if (i > 0) check($sformatf("stream%0d_spacing", i), w.t - rxget(1'b1, i - 1).t, 20);
    end
    check("stream_latency", rxget(1'b1, 0).t, acc20[0] + 1);
    // Pair 2 is offered across the drain edge and must land exactly one edge later
    check("drain_retry", acc20[1] - acc20[0], 2);
    check("steady_accept", acc20[2] - acc20[1], 20);

    // Reset at bit 7 of a word, with a second pair sitting in hold
    send(1'b0, 16'h1280, 16'h00FF, acc);
    base = rs16.nfr;
    wait_until(1'b0, 0, base + 1, "rst_word_frame");
    send(1'b0, 16'hDEAD, 16'hDEAD, acc);
    repeat (7) tick();
    check("bit7_outl", ol16, 1'b1);
    check("bit7_outr", or16, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_outl", ol16, 1'b0);
    check("async_outr", or16, 1'b0);
    check("async_status", st16, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    check("post_rst_ready", if16.P2S_ready, 1'b1);
    base = rs16.nfr;
    repeat (20) tick();
    check("post_rst_idle", rs16.nfr, base);
    sz = rx16.size();
    send(1'b0, 16'hBEEF, 16'h1234, acc);
    wait_until(1'b0, 1, sz + 1, "post_rst_word");
    w = rxget(1'b0, sz);
    check("post_rst_l", w.l, 16'hBEEF);
    check("post_rst_r", w.r, 16'h1234);
    check("post_rst_und", w.und, 1'b0);
    check("post_rst_latency", w.t, acc + 1);

    check("proto16", rs16.errs, 0);
    check("proto20", rs20.errs, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/p2s_tx.md
# p2s_tx

Stereo parallel-to-serial transmitter: the send side of the Frame/Dclk serial audio link whose receive side is S2P. It takes 16-bit left/right samples from the processing core over a valid/ready handshake, buffers one sample pair, and shifts both channels out MSB-first on two parallel lanes. Each word is marked with a one-cycle Frame strobe coincident with bit 15. It sits at the output of the audio processor, and its serial pins connect directly to an S2P-compatible receiver.

## Interface
Parameters:
- FRAME_LEN, 16, Dclk cycles between consecutive Frame strobes. Legal range 16..255; 16 gives back-to-back words.

Ports:
- Dclk  input  1  serial bit clock. All logic is on the rising edge; the receiver samples on the falling edge.
- Reset_n  input  1  asynchronous, active-low reset.
- P2S_L  input  16  left sample, two's complement.
- P2S_R  input  16  right sample, two's complement.
- P2S_valid  input  1  upstream sample pair is valid.
- P2S_ready  output  1  hold buffer empty; the pair is accepted on a rising edge when valid and ready are both 1.
- Frame  output  1  one-cycle strobe marking bit 15 of each word.
- OutputL  output  1  left serial data, MSB first.
- OutputR  output  1  right serial data, MSB first.
- P2S_status  output  1  1 while a word (bits 15..0) is on the lanes.
- Underrun  output  1  one-cycle pulse when a frame slot starts with the hold buffer empty.

## Operation
- Datapath:
  - One hold register pair (hold_L, hold_R, hold_full).
  - One shift register pair.
  - 5-bit bit counter; 8-bit frame timer.
- States:
  - IDLE: after reset; the frame timer is stopped. When hold_full=1, go to SHIFT on the next edge.
  - SHIFT: 16 cycles, driving bits 15..0. On exit, go to GAP if FRAME_LEN>16, else SHIFT again (a new frame starts).
  - GAP: FRAME_LEN-16 cycles; lanes and Frame are driven 0. On exit, go to SHIFT.
- Frame start is every SHIFT entry:
  - If hold_full=1: the shifter loads from hold and hold_full clears.
  - If hold_full=0: the shifter loads 0x0000 on both lanes (mute), Underrun pulses, and Frame is still asserted.
- Once out of IDLE, the block free-runs. The frame rate never depends on data availability, and it returns to IDLE only on reset.
- P2S_ready = !hold_full, registered.
- Simultaneous hold drain and valid: when a frame start drains hold on the same edge that valid is high, the new pair is not accepted, because ready was 0. It is accepted one edge later.
- Input data is captured only on acceptance. P2S_L and P2S_R may change freely at all other times.
- Reset mid-word:
  - Lanes go to 0 immediately.
  - The word in flight and any held sample are discarded.
  - The next word after reset starts with a fresh Frame.

## Timing
- Reset values:
  - Frame, OutputL, OutputR, P2S_status, Underrun = 0.
  - P2S_ready = 1.
  - Internal state: IDLE; hold_full = 0; counters 0.
- From IDLE, a pair accepted at edge k produces:
  - Frame=1 and bit 15 on both lanes during the cycle after edge k+1.
  - Bit i driven in the cycle after edge k+1+(15-i); bit 0 after edge k+16.
- P2S_status is 1 exactly during those 16 cycles.
- Frame strobes are exactly FRAME_LEN cycles apart in steady state.
- Underrun is asserted in the same cycle as the Frame it belongs to.
- All outputs are registered and change only after rising edges of Dclk, so they are stable at the receiver's falling-edge sample point.
- Throughput: one pair per FRAME_LEN cycles. Upstream sees ready rise the cycle after each frame start.

## Structure
- Shared package audio_pkg holds:
  - SAMPLE_W = 16.
  - The state enum: IDLE, SHIFT, GAP.
  - The mute constant 16'h0000.
- Sub-module p2s_lane, instantiated twice (L and R):
  - 16-bit load/shift-left register with load, shift and clear inputs.
  - Serial output taken from bit 15.
- The top level owns the FSM, the frame timer, the hold buffer and the handshake.

## Test plan
- Reset then idle, no valid for 50 cycles -> Frame never rises; lanes 0; P2S_ready=1.
- Single pair L=16'hA5C3, R=16'h0F0F with FRAME_LEN=16 -> Frame pulses one cycle; OutputL serialises 1010010111000011 and OutputR serialises 0000111100001111, MSB first; a loopback S2P reports S2P_L=A5C3, S2P_R=0F0F.
- Continuous valid, FRAME_LEN=20, pairs 0x0001..0x0008 -> Frame every 20 cycles; 4 zero gap cycles between words; all 8 words received in order; Underrun never pulses.
- Valid withheld after the first word -> next frame carries 0x0000 on both lanes, Underrun and Frame pulse together, and frame spacing is unchanged.
- Valid held high at the edge where hold drains -> the pair is accepted exactly one edge later, with no duplicate and no loss.
- Reset_n pulsed low at bit 7 of a word -> lanes drop to 0 asynchronously; after release the block is in IDLE with P2S_ready=1; the next accepted pair produces a clean frame.
